// File: rtl/qbert_pkg.sv
// Shared types and helpers for the Q*bert move controller: jump codes,
// layer state codes, cube indexing and request priority.
package qbert_pkg;

  typedef enum logic [2:0] {
    JUMP_NONE = 3'd0,
    JUMP_DR   = 3'd1,
    JUMP_DL   = 3'd2,
    JUMP_UR   = 3'd3,
    JUMP_UL   = 3'd4
  } jump_t;

  typedef enum logic [2:0] {
    QL_START = 3'd0,
    QL_JUMP  = 3'd1,
    QL_IDLE  = 3'd2,
    QL_KO    = 3'd3
  } qlayer_state_t;

  // Cube (r,c) sits at r(r+1)/2 + c; index 0 is the apex.
  function automatic int unsigned cube_index(input int unsigned r, input int unsigned c);
    return (r * (r + 1)) / 2 + c;
  endfunction

  // Simultaneous requests resolve DR > DL > UR > UL.
  function automatic jump_t pick_jump(input logic dr, input logic dl,
                                      input logic ur, input logic ul);
    if (dr) return JUMP_DR;
    if (dl) return JUMP_DL;
    if (ur) return JUMP_UR;
    if (ul) return JUMP_UL;
    return JUMP_NONE;
  endfunction

endpackage

// File: rtl/qbert_pyramid_nav.sv
// Combinational neighbour lookup: from (row, col) and a jump direction,
// returns the target cube and whether the jump leaves the pyramid.
module qbert_pyramid_nav
  import qbert_pkg::*;
#(
  parameter int unsigned N_ROWS = 7,
  parameter int unsigned N_cube = 28,
  parameter int unsigned RW     = 3
) (
  input  logic [RW-1:0]     row,
  input  logic [RW-1:0]     col,
  input  jump_t             dir,
  output logic [RW-1:0]     next_row,
  output logic [RW-1:0]     next_col,
  output logic [N_cube-1:0] next_onehot,
  output logic              bad
);

  int unsigned r, c, nr, nc;

  always_comb begin
    r   = 32'(row);
    c   = 32'(col);
    nr  = r;
    nc  = c;
    bad = 1'b0;
    case (dir)
      JUMP_DR: begin
        bad = (r + 1 == N_ROWS);
        nr  = r + 1;
        nc  = c + 1;
      end
      JUMP_DL: begin
        bad = (r + 1 == N_ROWS);
        nr  = r + 1;
      end
      // Up moves only decrement when legal, so no wrap leaks into next_row/col.
      JUMP_UR: begin
        bad = (r == 0) || (c + 1 > r);
        if (!bad) nr = r - 1;
      end
      JUMP_UL: begin
        bad = (r == 0) || (c == 0);
        if (!bad) begin
          nr = r - 1;
          nc = c - 1;
        end
      end
      default: bad = 1'b0;
    endcase
    next_row    = RW'(nr);
    next_col    = RW'(nc);
    next_onehot = bad ? '0 : (N_cube'(1) << cube_index(nr, nc));
  end

endmodule

// File: rtl/qbert_move_ctrl.sv
// Q*bert jump command initiator: turns direction pulses into layer commands,
// tracks the current cube, visited mask and jump/fall statistics.
// Define QBERT_CMD_QUEUE_EN to add a one-entry buffer for requests made while busy.
module qbert_move_ctrl
  import qbert_pkg::*;
#(
  parameter int unsigned N_ROWS = 7,
  parameter int unsigned N_cube = N_ROWS * (N_ROWS + 1) / 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              e_start_qb,
  input  logic              req_dr,
  input  logic              req_dl,
  input  logic              req_ur,
  input  logic              req_ul,
  input  logic              done_move,
  input  logic [2:0]        state_qb,
  output logic [2:0]        e_jump_qb,
  output logic [N_cube-1:0] e_next_qb,
  output logic [N_cube-1:0] position_qb,
  output logic              e_bad_jump,
  output logic [N_cube-1:0] cube_visited,
  output logic [15:0]       jump_cnt,
  output logic [3:0]        fall_cnt,
  output logic              busy
);

  localparam int unsigned RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam logic [N_cube-1:0] APEX = N_cube'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_ACK  = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_COMMIT    = 3'd3,
    S_WAIT_KO   = 3'd4,
    S_WAIT_IDLE = 3'd5
  } fsm_t;

  fsm_t              state;
  logic [RW-1:0]     row, col, tgt_row, tgt_col, nav_row, nav_col;
  logic [N_cube-1:0] nav_onehot;
  logic              nav_bad;
  jump_t             req_dir, issue_dir;

  assign req_dir = pick_jump(req_dr, req_dl, req_ur, req_ul);

`ifdef QBERT_CMD_QUEUE_EN
  logic  q_valid;
  jump_t q_dir;

  assign issue_dir = q_valid ? q_dir : req_dir;

  // Buffer the first request seen while a good jump may still be pending.
  always_ff @(posedge clk) begin
    if (!reset || e_start_qb) begin
      q_valid <= 1'b0;
      q_dir   <= JUMP_NONE;
    end else if (state == S_IDLE) begin
      q_valid <= 1'b0;
    end else if (state == S_WAIT_DONE && done_move && e_bad_jump) begin
      q_valid <= 1'b0;
    end else if ((state inside {S_WAIT_ACK, S_WAIT_DONE, S_COMMIT}) &&
                 !q_valid && req_dir != JUMP_NONE) begin
      q_valid <= 1'b1;
      q_dir   <= req_dir;
    end
  end
`else
  assign issue_dir = req_dir;
`endif

  qbert_pyramid_nav #(
    .N_ROWS (N_ROWS),
    .N_cube (N_cube),
    .RW     (RW)
  ) u_nav (
    .row         (row),
    .col         (col),
    .dir         (issue_dir),
    .next_row    (nav_row),
    .next_col    (nav_col),
    .next_onehot (nav_onehot),
    .bad         (nav_bad)
  );

  // Restart behaves like reset but keeps the statistics counters.
  always_ff @(posedge clk) begin
    if (!reset || e_start_qb) begin
      state        <= S_IDLE;
      row          <= '0;
      col          <= '0;
      tgt_row      <= '0;
      tgt_col      <= '0;
      position_qb  <= APEX;
      e_next_qb    <= APEX;
      e_jump_qb    <= JUMP_NONE;
      e_bad_jump   <= 1'b0;
      cube_visited <= '0;
      busy         <= 1'b0;
      if (!reset) begin
        jump_cnt <= '0;
        fall_cnt <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (issue_dir != JUMP_NONE) begin
            state      <= S_WAIT_ACK;
            busy       <= 1'b1;
            e_jump_qb  <= issue_dir;
            e_next_qb  <= nav_onehot;
            e_bad_jump <= nav_bad;
            tgt_row    <= nav_row;
            tgt_col    <= nav_col;
          end
        end
        S_WAIT_ACK: begin
          if (!done_move) state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (done_move) state <= e_bad_jump ? S_WAIT_KO : S_COMMIT;
        end
        S_COMMIT: begin
          position_qb  <= e_next_qb;
          row          <= tgt_row;
          col          <= tgt_col;
          cube_visited <= cube_visited | e_next_qb;
          if (jump_cnt != 16'hFFFF) jump_cnt <= jump_cnt + 16'd1;
          e_jump_qb    <= JUMP_NONE;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
        S_WAIT_KO: begin
          if (state_qb == QL_START) begin
            fall_cnt    <= fall_cnt + 4'd1;
            position_qb <= APEX;
            row         <= '0;
            col         <= '0;
            e_next_qb   <= APEX;
            e_jump_qb   <= JUMP_NONE;
            e_bad_jump  <= 1'b0;
            state       <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (state_qb == QL_IDLE) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qbert_move_ctrl.sv
// Bench for qbert_move_ctrl: directed scenarios plus randomized jumps,
// checked against a pyramid-geometry reference model.
module tb_qbert_move_ctrl;
  import qbert_pkg::*;

  localparam int NR = 7;
  localparam int NC = 28;

  logic          clk = 1'b0;
  logic          reset, e_start_qb, req_dr, req_dl, req_ur, req_ul, done_move;
  logic [2:0]    state_qb;
  logic [2:0]    e_jump_qb;
  logic [NC-1:0] e_next_qb, position_qb, cube_visited;
  logic          e_bad_jump, busy;
  logic [15:0]   jump_cnt;
  logic [3:0]    fall_cnt;

  qbert_move_ctrl #(.N_ROWS(NR)) dut (
    .clk          (clk),
    .reset        (reset),
    .e_start_qb   (e_start_qb),
    .req_dr       (req_dr),
    .req_dl       (req_dl),
    .req_ur       (req_ur),
    .req_ul       (req_ul),
    .done_move    (done_move),
    .state_qb     (state_qb),
    .e_jump_qb    (e_jump_qb),
    .e_next_qb    (e_next_qb),
    .position_qb  (position_qb),
    .e_bad_jump   (e_bad_jump),
    .cube_visited (cube_visited),
    .jump_cnt     (jump_cnt),
    .fall_cnt     (fall_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: position as (row, col), visited set, counters, request buffer.
  int            mr, mc, mjc, mfc;
  logic [NC-1:0] mvis;
  bit            m_q_valid;
  int            m_q_dir;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int idx(input int r, input int c);
    return r * (r + 1) / 2 + c;
  endfunction

  function automatic logic [NC-1:0] onehot(input int i);
    logic [NC-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // rq = {dr, dl, ur, ul}
  function automatic int prio(input bit [3:0] rq);
    if (rq[3]) return 1;
    if (rq[2]) return 2;
    if (rq[1]) return 3;
    if (rq[0]) return 4;
    return 0;
  endfunction

  // A move is legal iff the target lies on the triangle 0 <= c <= r < NR.
  task automatic target(input int d, output int nr, output int nc, output bit bad);
    nr = mr;
    nc = mc;
    case (d)
      1: begin nr = mr + 1; nc = mc + 1; end
      2: begin nr = mr + 1; end
      3: begin nr = mr - 1; end
      4: begin nr = mr - 1; nc = mc - 1; end
      default: ;
    endcase
    bad = !(nr >= 0 && nr < NR && nc >= 0 && nc <= nr);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input bit [3:0] rq);
    {req_dr, req_dl, req_ur, req_ul} = rq;
    tick();
    {req_dr, req_dl, req_ur, req_ul} = 4'b0000;
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_pos"},   position_qb,  onehot(idx(mr, mc)));
    check({tag, "_vis"},   cube_visited, mvis);
    check({tag, "_jcnt"},  jump_cnt,     mjc);
    check({tag, "_fcnt"},  fall_cnt,     mfc);
    check({tag, "_jump"},  e_jump_qb,    0);
    check({tag, "_bad"},   e_bad_jump,   0);
    check({tag, "_busy"},  busy,         0);
  endtask

  // Runs the layer handshake for a command issued at the previous edge.
  task automatic run_jump(input int d, input bit [3:0] noise, output bit queued);
    int nr, nc;
    bit bad;
    logic [NC-1:0] exp_next;
    queued = 1'b0;
    target(d, nr, nc, bad);
    exp_next = bad ? '0 : onehot(idx(nr, nc));
    check("issue_jump", e_jump_qb,   d);
    check("issue_next", e_next_qb,   exp_next);
    check("issue_bad",  e_bad_jump,  bad);
    check("issue_busy", busy,        1);
    check("issue_pos",  position_qb, onehot(idx(mr, mc)));
    repeat ($urandom_range(0, 2)) tick();
    done_move = 1'b0;
    {req_dr, req_dl, req_ur, req_ul} = noise;
    tick();
    {req_dr, req_dl, req_ur, req_ul} = 4'b0000;
`ifdef QBERT_CMD_QUEUE_EN
    if (noise != 0 && !m_q_valid) begin
      m_q_valid = 1'b1;
      m_q_dir   = prio(noise);
    end
`endif
    repeat ($urandom_range(0, 2)) tick();
    check("hold_jump", e_jump_qb, d);
    check("hold_next", e_next_qb, exp_next);
    done_move = 1'b1;
    tick();
    if (!bad) begin
      check("commit_busy", busy, 1);
      tick();
      mr = nr;
      mc = nc;
      mvis[idx(mr, mc)] = 1'b1;
      if (mjc < 65535) mjc++;
      check_idle_state("commit");
`ifdef QBERT_CMD_QUEUE_EN
      queued = m_q_valid;
`else
      if (noise != 0) begin
        tick();
        check("dropped_req_busy", busy, 0);
      end
`endif
    end else begin
      m_q_valid = 1'b0;
      check("ko_bad",  e_bad_jump, 1);
      check("ko_busy", busy,       1);
      state_qb = 3'd3;
      repeat ($urandom_range(1, 3)) tick();
      check("ko_hold", e_bad_jump, 1);
      state_qb = 3'd0;
      tick();
      mfc = (mfc + 1) % 16;
      mr  = 0;
      mc  = 0;
      check("ko_fcnt", fall_cnt,    mfc);
      check("ko_pos",  position_qb, onehot(0));
      check("ko_next", e_next_qb,   onehot(0));
      check("ko_jump", e_jump_qb,   0);
      check("ko_clr",  e_bad_jump,  0);
      check("ko_wait_busy", busy,   1);
      repeat ($urandom_range(0, 2)) tick();
      check("wait_idle_busy", busy, 1);
      state_qb = 3'd2;
      tick();
      check_idle_state("ko_done");
    end
  endtask

  task automatic do_jump(input bit [3:0] rq, input bit [3:0] noise);
    int d;
    bit q;
    pulse(rq);
    d = prio(rq);
    run_jump(d, noise, q);
    while (q) begin
      tick();
      d = m_q_dir;
      m_q_valid = 1'b0;
      run_jump(d, 4'b0000, q);
    end
  endtask

  task automatic model_home(input bit clear_counts);
    mr = 0;
    mc = 0;
    mvis = '0;
    m_q_valid = 1'b0;
    if (clear_counts) begin
      mjc = 0;
      mfc = 0;
    end
  endtask

  task automatic check_home(input string tag);
    check({tag, "_next"}, e_next_qb, onehot(0));
    check_idle_state(tag);
  endtask

  task automatic do_restart();
    e_start_qb = 1'b1;
    tick();
    e_start_qb = 1'b0;
    model_home(1'b0);
    check_home("restart");
  endtask

  logic [NC-1:0] exp20;

  initial begin
    reset = 1'b0; e_start_qb = 1'b0; done_move = 1'b1; state_qb = 3'd2;
    {req_dr, req_dl, req_ur, req_ul} = 4'b0000;
    model_home(1'b1);
    repeat (2) tick();
    reset = 1'b1;
    check_home("reset");

    // First DR from the apex lands on cube 2.
    do_jump(4'b1000, 4'b0000);
    check("first_dr_vis", cube_visited, 28'h4);

    // UL from the apex falls off.
    do_restart();
    do_jump(4'b0001, 4'b0000);

    // Down-left edge walk, seventh DL falls off.
    do_restart();
    repeat (7) do_jump(4'b0100, 4'b0000);

    // Right edge: UR from (6,6) is off the pyramid, UL reaches (5,5).
    do_restart();
    repeat (6) do_jump(4'b1000, 4'b0000);
    do_jump(4'b0010, 4'b0000);
    repeat (6) do_jump(4'b1000, 4'b0000);
    do_jump(4'b0001, 4'b0000);
    exp20 = onehot(20);
    check("ul_to_20", position_qb, exp20);

    // All four at once resolves to DR.
    do_restart();
    do_jump(4'b1111, 4'b0000);

    // Request while busy: buffered or ignored depending on build.
    do_restart();
    do_jump(4'b1000, 4'b0100);

    // Reset in the middle of a jump.
    pulse(4'b1000);
    done_move = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    done_move = 1'b1;
    model_home(1'b1);
    check_home("mid_reset");

    // Restart mid-jump keeps counters.
    do_jump(4'b1000, 4'b0000);
    pulse(4'b0100);
    done_move = 1'b0;
    tick();
    done_move = 1'b1;
    do_restart();

    // Three good jumps then restart keeps jump_cnt.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_home(1'b1);
    do_jump(4'b1000, 4'b0000);
    do_jump(4'b0100, 4'b0000);
    do_jump(4'b1000, 4'b0000);
    do_restart();
    check("start_keeps_jcnt", jump_cnt, 3);
    check("start_clears_vis", cube_visited, 0);

    // Randomized walk.
    for (int i = 0; i < 250; i++) begin
      bit [3:0] rq, nz;
      rq = 4'($urandom_range(1, 15));
      nz = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      if ($urandom_range(0, 24) == 0) do_restart();
      do_jump(rq, nz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
